bht_ckpt: RTL and testbench
===========================

# bht_ckpt

Parametrised branch history table with an integrated checkpoint/restore engine, the next generation of the frontend BHT. It provides INSTR_PER_FETCH taken/not-taken predictions per fetch from saturating counters of configurable width. On request, it streams its full state to memory as packed 64-bit words over a req/gnt data-cache port, or reloads that state from memory. Predictions and training are frozen while a transfer is in progress.

## Interface
- NR_ENTRIES, 1024: total entries; power of two, at least 2*INSTR_PER_FETCH.
- INSTR_PER_FETCH, 2: predictions per fetch; power of two.
- CTR_BITS, 2: saturating counter width, 1..7.
- VLEN, 64: PC width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  invalidate whole table.
- debug_mode_i  in  1  suppresses training.
- vpc_i  in  VLEN  fetch PC.
- pred_valid_o  out  INSTR_PER_FETCH  entry valid, per slot.
- pred_taken_o  out  INSTR_PER_FETCH  counter MSB, per slot.
- upd_valid_i  in  1  resolved branch.
- upd_pc_i  in  VLEN  resolved branch PC.
- upd_taken_i  in  1  resolved direction.
- save_start_i  in  1  pulse: begin checkpoint.
- restore_start_i  in  1  pulse: begin restore.
- base_addr_i  in  64  checkpoint region base; 8-byte aligned.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  request accepted.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  64  word address.
- mem_wdata_o  out  64  packed entries.
- mem_be_o  out  8  byte enables; 8'hFF on writes, 8'h00 on reads.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  64  read data.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse when a transfer completes.

## Operation
- Entry format: {valid, ctr[CTR_BITS-1:0]}, E = CTR_BITS+1 bits.
- Index: e = pc[$clog2(NR_ENTRIES):1]. Row = e / INSTR_PER_FETCH, column = low $clog2(INSTR_PER_FETCH) bits of e.
- Prediction: slot i of the row addressed by vpc_i. Outputs are forced to 0 while busy_o is high.
- Training applies only when upd_valid_i=1, debug_mode_i=0 and the state is IDLE:
  - Set valid to 1.
  - Increment the counter when taken, decrement it otherwise.
  - Saturate at 0 and at 2^CTR_BITS-1.
- Flush applies in IDLE only; it is ignored while busy. It clears every valid bit and sets every counter to weakly taken (MSB=1, other bits 0). Flush has priority over training in the same cycle.
- Packing:
  - EPW = 64/E entries per word.
  - NW = ceil(NR_ENTRIES/EPW) words.
  - Word w holds entries w*EPW+k at bits [k*E +: E].
  - Unused bits are written as 0 and ignored on restore.
  - Word w is at base_addr_i + 8*w. base_addr_i is sampled at start.
- FSM states: IDLE, SAVE, RD_REQ, RD_WAIT, DONE.
  - IDLE -> SAVE on save_start_i. If save_start_i and restore_start_i arrive together, save wins.
  - IDLE -> RD_REQ on restore_start_i.
  - Start pulses are ignored outside IDLE.
  - SAVE: mem_req_o=1 and mem_we_o=1. Address and data are held stable until mem_gnt_i. On grant, advance the word counter and present the next word in the next cycle, with no bubble. Grant of word NW-1 -> DONE.
  - RD_REQ: mem_req_o=1 and mem_we_o=0. Grant -> RD_WAIT.
  - RD_WAIT: mem_req_o=0. On mem_rvalid_i, write that word's entries into the table. Go to RD_REQ for the next word, or to DONE after word NW-1. Only one read is outstanding at a time.
  - DONE: done_o=1 for one cycle, then IDLE.
- The word counter is $clog2(NW)+1 bits and saturates. The last word is partial.
- A training event in the same cycle as a start pulse is applied, and a save includes it.

## Timing
- Reset: every entry is valid=0 with counter 0. FSM goes to IDLE. All outputs are 0, including pred_*, mem_*, busy_o and done_o.
- Predictions are combinational from table state. A training or flush write is visible the next cycle.
- busy_o rises the cycle after a start pulse and stays high through DONE. It falls together with done_o.
- Save with mem_gnt_i tied high: mem_req_o is high for exactly NW consecutive cycles. done_o is high the cycle after the last grant.
- Restore with grant and rvalid each arriving in the cycle after their request: 2 cycles per word. Restored entries are visible the cycle after done_o.
- Asserting rst_ni mid-transfer aborts immediately, with no further memory request. The table is cleared.

## Test plan
- Train PC 0x80000010 taken three times after reset -> its counter saturates at 3. pred_taken=1 in slot 0 when vpc_i=0x80000010. Two not-taken updates give counter 1 and pred_taken=0.
- Flush after training -> all pred_valid=0 and all counters 2. A flush while busy leaves the table unchanged.
- Save with defaults, base 0x1000, gnt tied high -> 49 writes to 0x1000..0x1180 with be=8'hFF. Word 48 holds 16 entries and bits [63:48]=0. done_o appears once.
- Save with gnt delayed 3 cycles per word -> addr and wdata stay stable while req is waiting. No word is skipped or repeated.
- Save, reset the table, then restore from the same region with random rvalid delay -> the table is bit-identical to the pre-save state. Predictions are 0 throughout the busy period.
- Assert save_start_i and restore_start_i together, then assert restore_start_i mid-save -> only the save runs. Asserting rst_ni mid-restore returns to IDLE with mem_req_o=0.

Source files
------------

// File: rtl/bht_ckpt.sv
// Branch history table of saturating counters with a checkpoint engine that
// streams the whole table to memory as packed 64-bit words, or reloads it.
module bht_ckpt #(
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned VLEN            = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    input  logic                       upd_valid_i,
    input  logic [VLEN-1:0]            upd_pc_i,
    input  logic                       upd_taken_i,
    input  logic                       save_start_i,
    input  logic                       restore_start_i,
    input  logic [63:0]                base_addr_i,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    output logic                       mem_we_o,
    output logic [63:0]                mem_addr_o,
    output logic [63:0]                mem_wdata_o,
    output logic [7:0]                 mem_be_o,
    input  logic                       mem_rvalid_i,
    input  logic [63:0]                mem_rdata_i,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned E     = CTR_BITS + 1;
    localparam int unsigned EPW   = 64 / E;
    localparam int unsigned NW    = (NR_ENTRIES + EPW - 1) / EPW;
    localparam int unsigned CNT_W = $clog2(NW) + 1;
    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        RD_REQ,
        RD_WAIT,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [E-1:0]        tbl_q [NR_ENTRIES];
    logic [CNT_W-1:0]    word_q;
    logic [63:0]         base_q;
    logic [31:0]         word_base;
    logic                last_word;
    logic                start_save, start_restore;
    logic                flush_en, train_en;
    logic [IDX_W-1:0]    upd_idx, vpc_idx, row_base;
    logic [CTR_BITS-1:0] ctr_cur, ctr_next;
    logic                unused_bits;

    assign unused_bits = ^{vpc_i, upd_pc_i, mem_rdata_i};

    assign upd_idx   = upd_pc_i[IDX_W:1];
    assign vpc_idx   = vpc_i[IDX_W:1];
    assign row_base  = vpc_idx & ~IDX_W'(INSTR_PER_FETCH - 1);
    assign word_base = 32'(word_q) * EPW;
    assign last_word = (word_q == CNT_W'(NW - 1));

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

    // Save takes precedence when both start pulses arrive together.
    assign start_save    = (state_q == IDLE) && save_start_i;
    assign start_restore = (state_q == IDLE) && restore_start_i && !save_start_i;
    assign flush_en      = (state_q == IDLE) && flush_i;
    assign train_en      = (state_q == IDLE) && upd_valid_i && !debug_mode_i && !flush_i;

    always_comb begin
        pred_valid_o = '0;
        pred_taken_o = '0;
        if (!busy_o) begin
            for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
                pred_valid_o[i] = tbl_q[row_base | IDX_W'(i)][E-1];
                pred_taken_o[i] = tbl_q[row_base | IDX_W'(i)][CTR_BITS-1];
            end
        end
    end

    assign ctr_cur = tbl_q[upd_idx][CTR_BITS-1:0];

    always_comb begin
        ctr_next = ctr_cur;
        if (upd_taken_i) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_BITS'(1);
        end else if (ctr_cur != '0) begin
            ctr_next = ctr_cur - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_be_o  = '0;
        unique case (state_q)
            IDLE: begin
                if (save_start_i)         state_d = SAVE;
                else if (restore_start_i) state_d = RD_REQ;
            end
            SAVE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                mem_be_o  = 8'hFF;
                if (mem_gnt_i && last_word) state_d = DONE;
            end
            RD_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid_i) state_d = last_word ? DONE : RD_REQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr_o = mem_req_o ? (base_q + (64'(word_q) << 3)) : '0;

    // Table is frozen while saving, so the presented word stays stable until granted.
    always_comb begin
        mem_wdata_o = '0;
        if (state_q == SAVE) begin
            for (int unsigned k = 0; k < EPW; k++) begin
                if (word_base + k < NR_ENTRIES)
                    mem_wdata_o[k*E +: E] = tbl_q[IDX_W'(word_base + k)];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            base_q <= '0;
        end else if (start_save || start_restore) begin
            word_q <= '0;
            base_q <= base_addr_i;
        end else if ((state_q == SAVE && mem_gnt_i) || (state_q == RD_WAIT && mem_rvalid_i)) begin
            if (word_q != '1) word_q <= word_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned e = 0; e < NR_ENTRIES; e++) tbl_q[IDX_W'(e)] <= '0;
        end else if (flush_en) begin
            for (int unsigned e = 0; e < NR_ENTRIES; e++) tbl_q[IDX_W'(e)] <= {1'b0, CTR_WEAK};
        end else if (train_en) begin
            tbl_q[upd_idx] <= {1'b1, ctr_next};
        end else if (state_q == RD_WAIT && mem_rvalid_i) begin
            // Entries past the end of the table in the final word are dropped.
            for (int unsigned k = 0; k < EPW; k++) begin
                if (word_base + k < NR_ENTRIES)
                    tbl_q[IDX_W'(word_base + k)] <= mem_rdata_i[k*E +: E];
            end
        end
    end

endmodule

// File: tb/tb_bht_ckpt.sv
// Randomized self-checking bench for bht_ckpt: table model, memory responder
// and a per-cycle compare of predictions and the memory port.
module tb_bht_ckpt;

    localparam int N    = 1024;
    localparam int IPF  = 2;
    localparam int CB   = 2;
    localparam int E    = CB + 1;
    localparam int EPW  = 64 / E;
    localparam int NW   = (N + EPW - 1) / EPW;
    localparam int MAXC = (1 << CB) - 1;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           flush_i = 1'b0;
    logic           debug_mode_i = 1'b0;
    logic [63:0]    vpc_i = '0;
    logic [IPF-1:0] pred_valid_o, pred_taken_o;
    logic           upd_valid_i = 1'b0;
    logic [63:0]    upd_pc_i = '0;
    logic           upd_taken_i = 1'b0;
    logic           save_start_i = 1'b0;
    logic           restore_start_i = 1'b0;
    logic [63:0]    base_addr_i = '0;
    logic           mem_req_o;
    logic           mem_gnt_i = 1'b0;
    logic           mem_we_o;
    logic [63:0]    mem_addr_o, mem_wdata_o;
    logic [7:0]     mem_be_o;
    logic           mem_rvalid_i = 1'b0;
    logic [63:0]    mem_rdata_i = '0;
    logic           busy_o, done_o;

    bht_ckpt #(
        .NR_ENTRIES(N), .INSTR_PER_FETCH(IPF), .CTR_BITS(CB), .VLEN(64)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .vpc_i(vpc_i), .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .save_start_i(save_start_i), .restore_start_i(restore_start_i),
        .base_addr_i(base_addr_i), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    bit          mvalid [N];
    logic [CB-1:0] mctr [N];
    bit          snap_valid [N];
    logic [CB-1:0] snap_ctr [N];
    bit          mbusy, mdone, msave, mwaiting;
    int          mw;
    logic [63:0] mbase;

    logic [63:0] mem [bit [63:0]];
    logic [63:0] wr_addr_q [$];
    logic [63:0] wr_data_q [$];

    bit          gnt_tied, gnt_fixed, rand_vpc;
    int          gnt_max, rv_max, cur_gnt_dly, cur_rv_dly, req_wait, rv_wait;
    int          rd_issued, rd_served;
    logic [63:0] rd_addr;
    bit          prev_wait;
    logic [63:0] prev_addr, prev_wdata;
    int          done_cnt, n_checks, n_fails;

    function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [11:0] lo;
        lo = 12'($urandom);
        if ($urandom_range(0, 1) == 0) lo[11:8] = 4'h0;
        return 64'h0000_0000_8000_0000 | 64'(lo);
    endfunction

    function automatic void model_reset();
        for (int e = 0; e < N; e++) begin
            mvalid[e] = 1'b0;
            mctr[e]   = '0;
        end
        mbusy = 0; mdone = 0; msave = 0; mwaiting = 0; mw = 0;
    endfunction

    function automatic logic [63:0] pack_word(int w);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < EPW; k++) begin
            int e;
            e = w * EPW + k;
            if (e < N) r[k*E +: E] = {mvalid[e], mctr[e]};
        end
        return r;
    endfunction

    function automatic void model_train(logic [63:0] pc, logic taken);
        int e, c;
        e = int'(pc[10:1]);
        c = int'(mctr[e]);
        if (taken) c = (c < MAXC) ? c + 1 : c;
        else       c = (c > 0) ? c - 1 : c;
        mvalid[e] = 1'b1;
        mctr[e]   = CB'(c);
    endfunction

    function automatic void model_advance();
        if (mdone) begin
            mdone = 0;
            mbusy = 0;
        end else if (!mbusy) begin
            if (flush_i) begin
                for (int e = 0; e < N; e++) begin
                    mvalid[e] = 1'b0;
                    mctr[e]   = CB'(1 << (CB - 1));
                end
            end else if (upd_valid_i && !debug_mode_i) begin
                model_train(upd_pc_i, upd_taken_i);
            end
            if (save_start_i || restore_start_i) begin
                mbusy = 1; msave = save_start_i; mw = 0; mwaiting = 0; mbase = base_addr_i;
            end
        end else if (msave) begin
            if (mem_req_o && mem_gnt_i) begin
                mem[mbase + 64'(8 * mw)] = mem_wdata_o;
                wr_addr_q.push_back(mem_addr_o);
                wr_data_q.push_back(mem_wdata_o);
                mw++;
                if (mw == NW) mdone = 1;
            end
        end else if (!mwaiting) begin
            if (mem_req_o && mem_gnt_i) begin
                mwaiting = 1;
                rd_addr  = mbase + 64'(8 * mw);
                rd_issued++;
            end
        end else if (mem_rvalid_i) begin
            for (int k = 0; k < EPW; k++) begin
                int e;
                logic [E-1:0] f;
                e = mw * EPW + k;
                f = mem_rdata_i[k*E +: E];
                if (e < N) begin
                    mvalid[e] = f[E-1];
                    mctr[e]   = f[CB-1:0];
                end
            end
            mw++;
            if (mw == NW) mdone = 1;
            else          mwaiting = 0;
        end
    endfunction

    // Per-cycle comparison against the model, then the model takes the clock edge.
    function automatic void check_cycle();
        logic [IPF-1:0] exp_v, exp_t;
        bit exp_req;
        if (!rst_ni) model_reset();
        for (int i = 0; i < IPF; i++) begin
            int e;
            e = (int'(vpc_i[10:1]) / IPF) * IPF + i;
            exp_v[i] = mbusy ? 1'b0 : mvalid[e];
            exp_t[i] = mbusy ? 1'b0 : mctr[e][CB-1];
        end
        check_output("pred_valid", 64'(pred_valid_o), 64'(exp_v));
        check_output("pred_taken", 64'(pred_taken_o), 64'(exp_t));
        check_output("busy", 64'(busy_o), 64'(mbusy));
        check_output("done", 64'(done_o), 64'(mdone));
        exp_req = mbusy && !mdone && (msave || !mwaiting);
        check_output("mem_req", 64'(mem_req_o), 64'(exp_req));
        if (exp_req && mem_req_o) begin
            check_output("mem_we", 64'(mem_we_o), 64'(msave));
            check_output("mem_addr", mem_addr_o, mbase + 64'(8 * mw));
            check_output("mem_be", 64'(mem_be_o), msave ? 64'hFF : 64'h0);
            if (msave) check_output("mem_wdata", mem_wdata_o, pack_word(mw));
        end
        if (prev_wait && mem_req_o) begin
            check_output("stable_addr", mem_addr_o, prev_addr);
            check_output("stable_wdata", mem_wdata_o, prev_wdata);
        end
        prev_wait  = rst_ni && mem_req_o && !mem_gnt_i;
        prev_addr  = mem_addr_o;
        prev_wdata = mem_wdata_o;
        if (done_o) done_cnt++;
        if (rst_ni) model_advance();
    endfunction

    function automatic void respond();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (!rst_ni) begin
            rd_served = rd_issued;
            req_wait  = 0;
            rv_wait   = 0;
        end else begin
            if (gnt_tied) begin
                mem_gnt_i = 1'b1;
            end else if (mem_req_o) begin
                if (req_wait >= cur_gnt_dly) begin
                    mem_gnt_i   = 1'b1;
                    req_wait    = 0;
                    cur_gnt_dly = gnt_fixed ? gnt_max : $urandom_range(0, gnt_max);
                end else begin
                    req_wait++;
                end
            end
            if (rd_served != rd_issued) begin
                if (rv_wait >= cur_rv_dly) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem[rd_addr];
                    rd_served++;
                    rv_wait      = 0;
                    cur_rv_dly   = $urandom_range(0, rv_max);
                end else begin
                    rv_wait++;
                end
            end
        end
    endfunction

    task automatic step();
        @(negedge clk_i);
        check_cycle();
        @(posedge clk_i);
        #1;
        respond();
        if (rand_vpc) vpc_i = rand_pc();
    endtask

    task automatic apply_stimulus(int cycles);
        for (int c = 0; c < cycles; c++) begin
            upd_valid_i  = ($urandom_range(0, 2) != 0);
            upd_pc_i     = rand_pc();
            upd_taken_i  = 1'($urandom_range(0, 1));
            debug_mode_i = ($urandom_range(0, 9) == 0);
            flush_i      = ($urandom_range(0, 63) == 0);
            step();
        end
        upd_valid_i = 0; debug_mode_i = 0; flush_i = 0;
    endtask

    task automatic wait_done(int budget);
        int c;
        c = 0;
        while (done_o !== 1'b1 && c < budget) begin
            step();
            c++;
        end
        check_output("xfer_timeout", 64'(c < budget), 64'd1);
        step();
    endtask

    initial begin
        int wr0, d0, errs;
        logic [63:0] w48;
        model_reset();
        n_checks = 0; n_fails = 0; done_cnt = 0;
        rd_issued = 0; rd_served = 0; prev_wait = 0;
        gnt_tied = 0; gnt_fixed = 1; gnt_max = 0; rv_max = 0;
        cur_gnt_dly = 0; cur_rv_dly = 0; req_wait = 0; rv_wait = 0; rand_vpc = 0;

        repeat (3) step();
        check_output("rst_req", 64'(mem_req_o), 64'd0);
        check_output("rst_we", 64'(mem_we_o), 64'd0);
        check_output("rst_addr", mem_addr_o, 64'd0);
        check_output("rst_wdata", mem_wdata_o, 64'd0);
        check_output("rst_be", 64'(mem_be_o), 64'd0);
        check_output("rst_busy", 64'(busy_o), 64'd0);
        check_output("rst_done", 64'(done_o), 64'd0);
        check_output("rst_pred", 64'({pred_valid_o, pred_taken_o}), 64'd0);
        rst_ni = 1'b1;
        step();

        // Directed training at PC 0x80000010 (entry 8, row 4, slot 0).
        vpc_i = 64'h8000_0010;
        upd_valid_i = 1; upd_pc_i = 64'h8000_0010; upd_taken_i = 1;
        repeat (3) step();
        upd_valid_i = 0;
        step();
        check_output("sat_model_ctr", 64'(mctr[8]), 64'd3);
        check_output("sat_pred_taken", 64'(pred_taken_o[0]), 64'd1);
        check_output("sat_pred_valid", 64'(pred_valid_o[0]), 64'd1);
        upd_valid_i = 1; upd_taken_i = 0;
        repeat (2) step();
        upd_valid_i = 0;
        step();
        check_output("nt_model_ctr", 64'(mctr[8]), 64'd1);
        check_output("nt_pred_taken", 64'(pred_taken_o[0]), 64'd0);

        rand_vpc = 1;
        apply_stimulus(300);
        flush_i = 1;
        step();
        flush_i = 0;
        #1;
        check_output("flush_valid", 64'(pred_valid_o), 64'd0);
        check_output("flush_taken", 64'(pred_taken_o), 64'h3);
        errs = 0;
        for (int e = 0; e < N; e++) if (mvalid[e] || mctr[e] != 2'd2) errs++;
        check_output("flush_model", 64'(errs), 64'd0);
        apply_stimulus(200);

        // Save with grant tied high; training in the start cycle, flush while busy.
        gnt_tied = 1;
        base_addr_i = 64'h1000;
        wr0 = wr_addr_q.size(); d0 = done_cnt;
        save_start_i = 1; upd_valid_i = 1; upd_pc_i = rand_pc(); upd_taken_i = 1;
        step();
        save_start_i = 0; upd_valid_i = 0;
        step();
        flush_i = 1;
        step();
        flush_i = 0;
        wait_done(200);
        check_output("save_count", 64'(wr_addr_q.size() - wr0), 64'd49);
        check_output("save_done_once", 64'(done_cnt - d0), 64'd1);
        if (wr_addr_q.size() >= wr0 + NW) begin
            w48 = wr_data_q[wr0 + 48];
            check_output("save_first_addr", wr_addr_q[wr0], 64'h1000);
            check_output("save_last_addr", wr_addr_q[wr0 + 48], 64'h1180);
            check_output("save_w48_pad", 64'(w48[63:48]), 64'd0);
        end

        // Delayed grants; simultaneous start pulses, then stray starts mid-save.
        gnt_tied = 0; gnt_fixed = 1; gnt_max = 3; cur_gnt_dly = 3; req_wait = 0;
        base_addr_i = 64'h4000;
        wr0 = wr_addr_q.size();
        save_start_i = 1; restore_start_i = 1;
        step();
        save_start_i = 0; restore_start_i = 0;
        repeat (20) step();
        restore_start_i = 1; save_start_i = 1;
        step();
        restore_start_i = 0; save_start_i = 0;
        wait_done(400);
        check_output("slow_save_count", 64'(wr_addr_q.size() - wr0), 64'd49);
        errs = 0;
        for (int i = 0; i < NW; i++)
            if (wr0 + i >= wr_addr_q.size() || wr_addr_q[wr0 + i] != 64'h4000 + 64'(8 * i)) errs++;
        check_output("slow_save_seq", 64'(errs), 64'd0);
        for (int e = 0; e < N; e++) begin
            snap_valid[e] = mvalid[e];
            snap_ctr[e]   = mctr[e];
        end

        // Wipe the table with reset, then restore with random latencies.
        rst_ni = 0;
        repeat (2) step();
        rst_ni = 1;
        step();
        gnt_fixed = 0; gnt_max = 2; rv_max = 4; cur_gnt_dly = 1; cur_rv_dly = 2;
        restore_start_i = 1;
        step();
        restore_start_i = 0;
        wait_done(1500);
        errs = 0;
        for (int e = 0; e < N; e++) if (mvalid[e] != snap_valid[e] || mctr[e] != snap_ctr[e]) errs++;
        check_output("restore_model", 64'(errs), 64'd0);
        gnt_tied = 1;
        base_addr_i = 64'h8000;
        save_start_i = 1;
        step();
        save_start_i = 0;
        wait_done(200);
        errs = 0;
        for (int i = 0; i < NW; i++)
            if (mem[64'h8000 + 64'(8 * i)] !== mem[64'h4000 + 64'(8 * i)]) errs++;
        check_output("restore_roundtrip", 64'(errs), 64'd0);

        // Reset in the middle of a restore aborts the transfer.
        gnt_tied = 0;
        base_addr_i = 64'h4000;
        restore_start_i = 1;
        step();
        restore_start_i = 0;
        repeat (10) step();
        rst_ni = 0;
        #1;
        check_output("abort_req", 64'(mem_req_o), 64'd0);
        check_output("abort_busy", 64'(busy_o), 64'd0);
        step();
        rst_ni = 1;
        repeat (5) step();
        check_output("post_abort_req", 64'(mem_req_o), 64'd0);
        check_output("post_abort_busy", 64'(busy_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
